// File: rtl/iddr_gear_rx.sv
// iddr_gear_rx: multi-lane DDR input capture with per-lane gearbox and shared bitslip
module iddr_gear_rx #(
  parameter int LANES = 1,
  parameter int GEAR = 4,
  parameter string GSR = "ENABLED",
  localparam int SW = (GEAR > 2) ? $clog2(GEAR) : 1,
  localparam int PW = (GEAR > 2) ? $clog2(GEAR / 2) : 1
) (
  input  logic                   SCLK,
  input  logic                   RSTB,
  input  logic [LANES-1:0]       D,
  input  logic                   SLIP,
  output logic [LANES*GEAR-1:0]  Q,
  output logic                   QVALID,
  output logic [SW-1:0]          SLIP_OFF
);
  localparam logic [PW-1:0] P_LAST = PW'(GEAR / 2 - 1);
  localparam logic [SW-1:0] OFF_LAST = SW'(GEAR - 1);
  logic gsr_n, pur_n, rst;
  logic prime_d, prime_q;
  logic [LANES-1:0] r_d, r_q, f_d, f_q;
  logic [LANES-1:0][2*GEAR-1:0] h_sh, h_d, h_q;
  logic [PW-1:0] p_d, p_q;
  logic [SW-1:0] off_inc, off_d, off_q;
  logic [LANES*GEAR-1:0] q_d, q_q;
  logic word, qv_d, qv_q;
  // Global set/reset and power-up reset nets: inactive-high here, driven low by the device's global networks
  assign gsr_n = 1'b1;
  assign pur_n = 1'b1;
  assign rst = RSTB || (GSR == "ENABLED" && !gsr_n) || !pur_n;
  // Next state; prime_q holds the phase on the release edge so the first word carries only post-reset bits
  always_comb begin
    h_sh = '0;
    h_d = '0;
    q_d = q_q;
    prime_d = rst;
    r_d = rst ? '0 : D;
    f_d = rst ? '0 : D;
    off_inc = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
    off_d = rst ? '0 : SLIP ? off_inc : off_q;
    word = !rst && !prime_q && p_q == P_LAST;
    p_d = (rst || prime_q || word) ? '0 : p_q + 1'b1;
    qv_d = word;
    for (int l = 0; l < LANES; l++) begin
      h_sh[l] = {h_q[l][2*GEAR-3:0], r_q[l], f_q[l]};
      h_d[l] = rst ? '0 : h_sh[l];
      q_d[l*GEAR +: GEAR] = rst ? '0 : word ? h_sh[l][off_d +: GEAR] : q_q[l*GEAR +: GEAR];
    end
  end
  // Rising-edge capture, history, phase, offset and registered outputs
  always_ff @(posedge SCLK) begin
    prime_q <= prime_d;
    r_q <= r_d;
    h_q <= h_d;
    p_q <= p_d;
    off_q <= off_d;
    q_q <= q_d;
    qv_q <= qv_d;
  end
  // Falling-edge capture; reset is sampled on this edge as well
  always_ff @(negedge SCLK) f_q <= f_d;
  assign Q = q_q;
  assign QVALID = qv_q;
  assign SLIP_OFF = off_q;
endmodule

// File: tb/tb_iddr_gear_rx.sv
// tb_iddr_gear_rx: directed checks of gear 2/4/8 capture, bitslip, reset and global reset
module tb_iddr_gear_rx;
  logic SCLK = 1'b0;
  logic RSTB = 1'b1;
  logic SLIP = 1'b0;
  logic d1 = 1'b0;
  logic [1:0] d8 = '0;
  logic [3:0] q4, q4d;
  logic v4, v4d, v2, v8;
  logic [1:0] o4, o4d, q2;
  logic [0:0] o2;
  logic [15:0] q8;
  logic [2:0] o8;
  int n_chk = 0;
  int n_fail = 0;

  always #5 SCLK = ~SCLK;

  iddr_gear_rx #(.LANES(1), .GEAR(4), .GSR("ENABLED")) u4 (
    .SCLK(SCLK), .RSTB(RSTB), .D(d1), .SLIP(SLIP), .Q(q4), .QVALID(v4), .SLIP_OFF(o4));
  iddr_gear_rx #(.LANES(1), .GEAR(4), .GSR("DISABLED")) u4d (
    .SCLK(SCLK), .RSTB(RSTB), .D(d1), .SLIP(SLIP), .Q(q4d), .QVALID(v4d), .SLIP_OFF(o4d));
  iddr_gear_rx #(.LANES(1), .GEAR(2)) u2 (
    .SCLK(SCLK), .RSTB(RSTB), .D(d1), .SLIP(SLIP), .Q(q2), .QVALID(v2), .SLIP_OFF(o2));
  iddr_gear_rx #(.LANES(2), .GEAR(8)) u8 (
    .SCLK(SCLK), .RSTB(RSTB), .D(d8), .SLIP(SLIP), .Q(q8), .QVALID(v8), .SLIP_OFF(o8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One SCLK cycle: dr bits present at the rising edge, df bits at the falling edge; {lane1_8, lane0_8, d1}
  task automatic cyc(input logic [2:0] dr, input logic [2:0] df, input logic s);
    d1 = dr[0];
    d8 = dr[2:1];
    SLIP = s;
    @(posedge SCLK);
    #1;
    d1 = df[0];
    d8 = df[2:1];
    @(negedge SCLK);
    #1;
  endtask

  initial begin
    logic [7:0] n;
    logic [7:0] np;
    int j;
    logic br, bf;
    repeat (3) cyc(3'b001, 3'b000, 1'b0);
    chk("rst_q4", 32'(q4), 32'h0);
    chk("rst_v4", 32'(v4), 32'h0);
    chk("rst_o4", 32'(o4), 32'h0);
    chk("rst_v2", 32'(v2), 32'h0);
    RSTB = 1'b0;
    cyc(3'b001, 3'b000, 1'b0);
    chk("e0_v4", 32'(v4), 32'h0);
    chk("e0_v2", 32'(v2), 32'h0);
    cyc(3'b001, 3'b000, 1'b0);
    chk("e1_v4", 32'(v4), 32'h0);
    chk("e1_v2", 32'(v2), 32'h1);
    chk("e1_q2", 32'(q2), 32'h2);
    cyc(3'b001, 3'b000, 1'b0);
    chk("e2_v4", 32'(v4), 32'h1);
    chk("e2_q4", 32'(q4), 32'hA);
    chk("e2_q4d", 32'(q4d), 32'hA);
    chk("e2_v2", 32'(v2), 32'h1);
    cyc(3'b001, 3'b000, 1'b1);
    chk("e3_o4", 32'(o4), 32'h1);
    chk("e3_v4", 32'(v4), 32'h0);
    chk("e3_q4_hold", 32'(q4), 32'hA);
    cyc(3'b001, 3'b000, 1'b0);
    chk("e4_v4", 32'(v4), 32'h1);
    chk("e4_q4_slip1", 32'(q4), 32'h5);
    cyc(3'b001, 3'b000, 1'b1);
    chk("e5_o4", 32'(o4), 32'h2);
    cyc(3'b001, 3'b000, 1'b1);
    chk("e6_o4", 32'(o4), 32'h3);
    chk("e6_v4", 32'(v4), 32'h1);
    chk("e6_q4_slip3", 32'(q4), 32'h5);
    cyc(3'b001, 3'b000, 1'b1);
    chk("e7_o4_wrap", 32'(o4), 32'h0);
    chk("e7_v4", 32'(v4), 32'h0);
    cyc(3'b001, 3'b000, 1'b0);
    chk("e8_v4", 32'(v4), 32'h1);
    chk("e8_q4", 32'(q4), 32'hA);
    cyc(3'b001, 3'b000, 1'b1);
    chk("e9_o4", 32'(o4), 32'h1);
    chk("e9_v4", 32'(v4), 32'h0);
    RSTB = 1'b1;
    cyc(3'b001, 3'b000, 1'b0);
    chk("mid_rst_v4", 32'(v4), 32'h0);
    chk("mid_rst_q4", 32'(q4), 32'h0);
    chk("mid_rst_o4", 32'(o4), 32'h0);
    chk("mid_rst_v8", 32'(v8), 32'h0);
    RSTB = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      n = 8'(k / 4);
      j = k % 4;
      br = n[7 - 2 * j];
      bf = n[6 - 2 * j];
      cyc({~br, br, 1'b1}, {~bf, bf, 1'b0}, 1'b0);
      if (k < 2) chk($sformatf("rel%0d_v4", k), 32'(v4), 32'h0);
      if (k == 2) begin
        chk("rel2_v4", 32'(v4), 32'h1);
        chk("rel2_q4", 32'(q4), 32'hA);
      end
      if (k == 5 || k == 3) chk($sformatf("rel%0d_v8", k), 32'(v8), 32'h0);
      if (k > 0 && k % 4 == 0) begin
        np = 8'(k / 4 - 1);
        chk($sformatf("rel%0d_v8", k), 32'(v8), 32'h1);
        chk($sformatf("rel%0d_q8", k), 32'(q8), 32'({~np, np}));
      end
    end
    force u4.gsr_n = 1'b0;
    force u4d.gsr_n = 1'b0;
    cyc(3'b001, 3'b000, 1'b1);
    release u4.gsr_n;
    release u4d.gsr_n;
    chk("gsr_v4", 32'(v4), 32'h0);
    chk("gsr_q4", 32'(q4), 32'h0);
    chk("gsr_o4", 32'(o4), 32'h0);
    chk("gsr_dis_o4d", 32'(o4d), 32'h1);
    chk("gsr_dis_q4d", 32'(q4d), 32'hA);
    cyc(3'b001, 3'b000, 1'b0);
    chk("gsr1_v4", 32'(v4), 32'h0);
    chk("gsr1_v4d", 32'(v4d), 32'h1);
    chk("gsr1_q4d", 32'(q4d), 32'h5);
    cyc(3'b001, 3'b000, 1'b0);
    cyc(3'b001, 3'b000, 1'b0);
    chk("gsr3_v4", 32'(v4), 32'h1);
    chk("gsr3_q4", 32'(q4), 32'hA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iddr_gear_rx.md
# iddr_gear_rx

Parametrised multi-lane DDR input capture and deserialiser, the successor to the single-lane x2 input DDR cell. Each lane samples D on both SCLK edges, builds a per-lane bit history, and emits GEAR-bit words every GEAR/2 SCLK cycles. A bitslip control aligns words to the serial stream. It sits directly behind the I/O pads of source-synchronous receive interfaces, feeding link training and word-alignment logic in the SCLK domain.

## Interface
- LANES, 1, number of independent serial lanes (1..16).
- GEAR, 4, bits per lane per output word; legal values 2, 4, 8.
- GSR, "ENABLED", "ENABLED": global set/reset network ORed into RSTB; "DISABLED": only the power-up reset is ORed in.
- SCLK  in  1  capture clock; data sampled on both edges, all other state on the rising edge.
- RSTB  in  1  reset, synchronous, active-high.
- D  in  LANES  serial DDR data, one bit per lane.
- SLIP  in  1  bitslip request, sampled on the SCLK rising edge.
- Q  out  LANES*GEAR  output words; lane n at Q[n*GEAR +: GEAR], oldest bit at the MSB.
- QVALID  out  1  one-cycle strobe; Q is updated on the same edge.
- SLIP_OFF  out  clog2(GEAR) (min 1)  current bit offset, 0..GEAR-1.

## Operation
- Per lane: rise flop R captures D on the rising edge; fall flop F captures D on the falling edge. Stream order is R before F.
- On each rising edge with reset inactive, the pair (R,F) from the previous cycle shifts into the 2*GEAR-bit history H: H <= {H[2G-3:0], R, F}. The newest bit is at the LSB.
- Phase counter P counts 0..GEAR/2-1 and wraps. On the edge where P == GEAR/2-1, Q[lane] <= Hnext[off+GEAR-1 : off], where Hnext is the post-shift value, and QVALID <= 1. On all other edges QVALID <= 0 and Q holds.
- GEAR == 2: P is constant 0, so QVALID is high on every edge after reset.
- SLIP:
  - Each rising edge with SLIP=1 sets off <= off+1, selecting one bit older.
  - From GEAR-1, off wraps to 0, moving the window GEAR-1 bits newer. Net effect is +1 bit with one word boundary skipped.
  - The new offset applies to the next emitted word, including a word emitted on the same edge as the slip.
  - SLIP held high slips once per cycle. SLIP has no effect during reset.
- Effective reset = RSTB | ~GSR_net (when GSR="ENABLED") | ~PUR_net.
- Reset values: R, F, H, P, off, Q all 0; QVALID 0. The fall flops also reset synchronously, sampling reset on the falling edge.
- Lanes share P, off and SLIP. There is no per-lane alignment.

## Timing
- Let edge e0 be the first rising edge that samples reset low. The first QVALID occurs at edge e(GEAR/2), then every GEAR/2 edges.
- Capture-to-word latency: a bit sampled at rising edge k (or at the following falling edge) enters H at edge k+1. It is visible in Q at the first word boundary ≥ k+1 whose window covers it.
- Bits from before or during reset read as 0 in the first word(s).
- Reset asserted mid-word: at the next rising edge, P, H, off and Q clear and QVALID is 0. No partial word is emitted.
- SLIP and a word boundary on the same edge: the word uses the incremented offset.
- Q/QVALID are registered, with no combinational path from D or SLIP.

## Test plan
- LANES=1, GEAR=4, reset 3 cycles, then drive D=1 on rising/0 on falling every cycle. Required: first QVALID at e2, Q=4'b1010, then QVALID every 2nd edge with Q=4'b1010.
- Same stream, one SLIP pulse between words. Required: SLIP_OFF=1, next word Q=4'b0101. Three more pulses: SLIP_OFF wraps 3→0.
- LANES=2, GEAR=8, lane0 driven with incrementing byte 0x00,0x01,… (MSB first), lane1 with the complement. Required: after aligning with SLIP to offset 0, Q[7:0]=n and Q[15:8]=~n on consecutive QVALIDs, spaced 4 edges apart.
- GEAR=2: QVALID high every cycle after e0. Q equals {R,F} from the previous cycle.
- Assert RSTB for 1 cycle while P=1 (GEAR=4). Required: no QVALID on the following edge, Q=0, SLIP_OFF=0, and the first QVALID 2 edges after release.
- GSR="ENABLED", pulse the global reset low with RSTB=0. Required: all outputs clear exactly as with RSTB. With GSR="DISABLED", the outputs are unaffected.
